// File: rtl/right_tail_seq.sv
// Right tail-lamp sequencer: outward center-to-edge sweep, brake steady-on,
// optional hazard flash compiled in with the HAZARD_EN macro.
module right_tail_seq #(
    parameter int unsigned STEP_CYCLES = 67108864
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       RightReq,
    input  logic       Brake,
    input  logic       Hazard,
    output logic [2:0] Right,
    output logic       StepTick,
    output logic       Busy
);

    localparam int unsigned CW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(STEP_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        R1,
        R2,
        R3,
        GAP
`ifdef HAZARD_EN
        ,
        HAZ_ON,
        HAZ_OFF
`endif
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_adv;
    logic          step_tick;
    logic [1:0]    req_sync;
    logic [1:0]    brk_sync;
    logic          req_s;
    logic          brk_s;

`ifdef HAZARD_EN
    logic [1:0]    haz_sync;
    logic          haz_s;
    logic          in_haz;

    assign haz_s  = haz_sync[1];
    assign in_haz = (state == HAZ_ON) || (state == HAZ_OFF);
`else
    logic          unused_hazard;

    assign unused_hazard = Hazard;
`endif

    assign req_s     = req_sync[1];
    assign brk_s     = brk_sync[1];
    // Count is forced to 0 in IDLE, so no tick can appear there.
    assign step_tick = (cnt == CNT_MAX);
    assign cnt_adv   = step_tick ? '0 : cnt + CW'(1);
    assign StepTick  = step_tick;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            req_sync <= '0;
            brk_sync <= '0;
`ifdef HAZARD_EN
            haz_sync <= '0;
`endif
            state    <= IDLE;
            cnt      <= '0;
            Right    <= '0;
            Busy     <= 1'b0;
        end else begin
            req_sync <= {req_sync[0], RightReq};
            brk_sync <= {brk_sync[0], Brake};
`ifdef HAZARD_EN
            haz_sync <= {haz_sync[0], Hazard};
            // Hazard pre-empts every non-hazard state, including brake in IDLE.
            if (haz_s && !in_haz) begin
                state <= HAZ_ON;
                cnt   <= '0;
                Right <= '1;
                Busy  <= 1'b1;
            end else
`endif
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (req_s) begin
                        state <= R1;
                        Right <= 3'b100;
                        Busy  <= 1'b1;
                    end else begin
                        Right <= {3{brk_s}};
                        Busy  <= 1'b0;
                    end
                end
                R1: begin
                    cnt <= cnt_adv;
                    if (step_tick) begin
                        state <= R2;
                        Right <= 3'b110;
                    end
                end
                R2: begin
                    cnt <= cnt_adv;
                    if (step_tick) begin
                        state <= R3;
                        Right <= 3'b111;
                    end
                end
                R3: begin
                    cnt <= cnt_adv;
                    if (step_tick) begin
                        state <= GAP;
                        Right <= 3'b000;
                    end
                end
                GAP: begin
                    cnt <= cnt_adv;
                    if (step_tick) begin
                        if (req_s) begin
                            state <= R1;
                            Right <= 3'b100;
                        end else begin
                            state <= IDLE;
                            Right <= {3{brk_s}};
                            Busy  <= 1'b0;
                        end
                    end
                end
`ifdef HAZARD_EN
                HAZ_ON, HAZ_OFF: begin
                    if (!haz_s) begin
                        state <= IDLE;
                        cnt   <= '0;
                        Right <= {3{brk_s}};
                        Busy  <= 1'b0;
                    end else begin
                        cnt <= cnt_adv;
                        if (step_tick) begin
                            state <= (state == HAZ_ON) ? HAZ_OFF : HAZ_ON;
                            Right <= (state == HAZ_ON) ? 3'b000 : 3'b111;
                        end
                    end
                end
`endif
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                    Right <= '0;
                    Busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_right_tail_seq.sv
// Scoreboard bench for right_tail_seq (STEP_CYCLES=4); expected {Busy,StepTick,Right}
// per cycle is queued with the stimulus and compared #1 after each clock edge.
module tb_right_tail_seq;

    logic       Clk;
    logic       Rst;
    logic       RightReq;
    logic       Brake;
    logic       Hazard;
    logic [2:0] Right;
    logic       StepTick;
    logic       Busy;

    int unsigned n_checks;
    int unsigned n_errors;
    logic [4:0]  exp_q[$];
    string       phase;

    right_tail_seq #(.STEP_CYCLES(4)) dut (
        .Clk      (Clk),
        .Rst      (Rst),
        .RightReq (RightReq),
        .Brake    (Brake),
        .Hazard   (Hazard),
        .Right    (Right),
        .StepTick (StepTick),
        .Busy     (Busy)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [4:0] got, input logic [4:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%b exp=%b (busy,tick,right)", tag, got, exp);
        end
    endtask

    task automatic push(input logic busy, input logic tick, input logic [2:0] r, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back({busy, tick, r});
    endtask

    // One full step of a lamp pattern while busy: tick on the last of four cycles.
    task automatic push_step(input logic [2:0] r);
        push(1'b1, 1'b0, r, 3);
        push(1'b1, 1'b1, r, 1);
    endtask

    task automatic sample(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge Clk);
            #1;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL %s scoreboard empty got=%b", phase, {Busy, StepTick, Right});
            end else begin
                check(phase, {Busy, StepTick, Right}, exp_q.pop_front());
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        RightReq = 1'b0;
        Brake    = 1'b0;
        Hazard   = 1'b0;
        Rst      = 1'b0;
        #1 Rst = 1'b1;
        #1 check("reset_state", {Busy, StepTick, Right}, 5'b0);
        #20 Rst = 1'b0;
        @(posedge Clk);
        #1;

        // Basic sweep, then release during the second R1.
        phase = "basic_sweep";
        RightReq = 1'b1;
        push(1'b0, 1'b0, 3'b000, 2);
        push_step(3'b100);
        push_step(3'b110);
        push_step(3'b111);
        push_step(3'b000);
        push_step(3'b100);
        sample(19);
        phase = "early_release";
        RightReq = 1'b0;
        push_step(3'b110);
        push_step(3'b111);
        push_step(3'b000);
        push(1'b0, 1'b0, 3'b000, 4);
        sample(19);

        // Asynchronous reset while Right=110.
        phase = "pre_reset";
        RightReq = 1'b1;
        push(1'b0, 1'b0, 3'b000, 2);
        push_step(3'b100);
        push(1'b1, 1'b0, 3'b110, 1);
        sample(7);
        #2 Rst = 1'b1;
        #1 check("reset_async", {Busy, StepTick, Right}, 5'b0);
        RightReq = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge Clk);
            #1 check("reset_hold", {Busy, StepTick, Right}, 5'b0);
        end
        #2 Rst = 1'b0;
        phase = "post_reset";
        push(1'b0, 1'b0, 3'b000, 4);
        sample(4);

        // Brake in IDLE, ignored during a sweep, back after it.
        phase = "brake_idle";
        Brake = 1'b1;
        push(1'b0, 1'b0, 3'b000, 2);
        push(1'b0, 1'b0, 3'b111, 3);
        sample(5);
        phase = "brake_sweep";
        RightReq = 1'b1;
        push(1'b0, 1'b0, 3'b111, 2);
        push_step(3'b100);
        push_step(3'b110);
        push_step(3'b111);
        push_step(3'b000);
        sample(3);
        RightReq = 1'b0;
        push(1'b0, 1'b0, 3'b111, 3);
        sample(18);
        phase = "brake_release";
        Brake = 1'b0;
        push(1'b0, 1'b0, 3'b111, 2);
        push(1'b0, 1'b0, 3'b000, 2);
        sample(4);

        // Sub-cycle glitch is never sampled; a 3-cycle pulse gives exactly one sweep.
        phase = "glitch_short";
        RightReq = 1'b1;
        #3 RightReq = 1'b0;
        push(1'b0, 1'b0, 3'b000, 6);
        sample(6);
        phase = "glitch_3cyc";
        RightReq = 1'b1;
        push(1'b0, 1'b0, 3'b000, 2);
        push_step(3'b100);
        push_step(3'b110);
        push_step(3'b111);
        push_step(3'b000);
        push(1'b0, 1'b0, 3'b000, 3);
        sample(3);
        RightReq = 1'b0;
        sample(18);

`ifdef HAZARD_EN
        phase = "haz_pre";
        RightReq = 1'b1;
        push(1'b0, 1'b0, 3'b000, 2);
        push_step(3'b100);
        push(1'b1, 1'b0, 3'b110, 1);
        sample(7);
        phase = "haz_flash";
        RightReq = 1'b0;
        Hazard   = 1'b1;
        Brake    = 1'b1;
        push(1'b1, 1'b0, 3'b110, 2);
        push_step(3'b111);
        push_step(3'b000);
        push_step(3'b111);
        sample(14);
        phase = "haz_release";
        Hazard = 1'b0;
        push(1'b1, 1'b0, 3'b000, 2);
        push(1'b0, 1'b0, 3'b111, 3);
        sample(5);
        phase = "haz_brake_off";
        Brake = 1'b0;
        push(1'b0, 1'b0, 3'b111, 2);
        push(1'b0, 1'b0, 3'b000, 2);
        sample(4);
`else
        phase = "haz_ignored_idle";
        Hazard = 1'b1;
        push(1'b0, 1'b0, 3'b000, 6);
        sample(6);
        phase = "haz_ignored_sweep";
        RightReq = 1'b1;
        push(1'b0, 1'b0, 3'b000, 2);
        push_step(3'b100);
        push_step(3'b110);
        push_step(3'b111);
        push_step(3'b000);
        push(1'b0, 1'b0, 3'b000, 3);
        sample(3);
        RightReq = 1'b0;
        sample(18);
        Hazard = 1'b0;
`endif

        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
